uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer clocked by the baud clock that the UART clock divider produces. It sits directly downstream of the divider. It accepts one parallel byte per frame through a valid/ready handshake. It shifts out start, data (LSB first), optional parity and stop bits on a single serial line.

## Interface
- DATA_WIDTH, 8: data bits per frame (5–8 legal).
- STOP_BITS, 1: stop bits per frame (1 or 2).
- i_uart_tx_clk  input  1  baud clock; one bit period per cycle.
- i_uart_tx_rst_n  input  1  reset; synchronous, active-low.
- i_uart_tx_data  input  DATA_WIDTH  byte to send; sampled only at accept.
- i_uart_tx_valid  input  1  upstream has a byte.
- i_uart_tx_par_en  input  1  runtime parity enable; sampled at accept.
- i_uart_tx_par_type  input  1  0 = even, 1 = odd; sampled at accept.
- o_uart_tx_ready  output  1  serializer can accept a byte this cycle.
- o_uart_tx_serial  output  1  serial line; idles high.
- o_uart_tx_busy  output  1  a frame is in progress.
- o_uart_tx_done  output  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept occurs when i_uart_tx_valid && o_uart_tx_ready at a rising edge.
  - Latch data, par_en and par_type into holding registers.
  - Next state is START.
- START: serial = 0 for 1 cycle, then go to DATA with bit_cnt = 0.
- DATA: serial = data[bit_cnt], LSB first. bit_cnt counts to DATA_WIDTH-1.
  - Leave DATA for PARITY if the latched par_en is 1, otherwise for STOP.
- PARITY: serial = ^data for even, ~^data for odd. Lasts 1 cycle, then STOP.
- STOP: serial = 1 for STOP_BITS cycles, tracked by stop_cnt.
  - After the last stop bit, go to START if a byte was accepted, otherwise to IDLE.
- o_uart_tx_ready = (state == IDLE) || (state == STOP && last stop bit). This allows back-to-back frames with no extra idle bit.
- o_uart_tx_busy = (state != IDLE).
- Input changes after accept do not affect the frame in flight.
- bit_cnt width is $clog2(DATA_WIDTH). It wraps to 0 on DATA exit.

## Timing
- Reset values: o_uart_tx_serial = 1, o_uart_tx_ready = 1, o_uart_tx_busy = 0, o_uart_tx_done = 0. State = IDLE, all counters 0.
- Reset wins over every other event, including accept in the same cycle.
- Reset mid-frame aborts the frame:
  - Next cycle serial = 1 and state = IDLE.
  - No done pulse is produced.
- o_uart_tx_serial is registered. The start bit appears in the cycle after the accept edge.
- Frame length in cycles = 1 + DATA_WIDTH + parity + STOP_BITS. With defaults and parity on, this is 11.
- o_uart_tx_done is registered. It is high for exactly 1 cycle: the cycle after the last stop-bit cycle.
  - It pulses even when a back-to-back frame starts in that same cycle.
- With valid held high continuously, consecutive frames are gapless: the last stop bit is followed directly by the next start bit.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state and parity logic are compiled in.
  - i_uart_tx_par_en and i_uart_tx_par_type are honoured.
- UART_TX_PARITY_EN undefined:
  - PARITY state and parity logic are removed.
  - The par ports remain, are ignored, and must not generate lint-relevant logic.
  - Every frame is 1 + DATA_WIDTH + STOP_BITS cycles.

## Structure
- uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - localparams UART_PAR_EVEN = 1'b0 and UART_PAR_ODD = 1'b1;
  - localparams UART_IDLE_LVL = 1'b1 and UART_START_LVL = 1'b0.
- Sub-module uart_parity_calc: combinational. Inputs are data and par_type; output is the parity bit. It is instantiated only under UART_TX_PARITY_EN.
- Top level holds the FSM, holding registers, counters and output registers.

## Test plan
- Reset: hold i_uart_tx_rst_n = 0 for 2 cycles with valid = 1.
  - Required: serial = 1, ready = 1, busy = 0, done = 0, and no frame starts.
- Send 0xA5 with even parity, 1 stop bit.
  - Serial: 0, then data 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
  - busy is high for 11 cycles, then done pulses once.
- Send 0x01 with odd parity. Required parity bit = 0.
- Send 0x03 with odd parity. Required parity bit = 1.
- Hold valid high and send 0x55, then 0x0F.
  - Required: stop bit of frame 1 is followed immediately by the start bit of frame 2.
  - Required: 2 done pulses, 11 cycles apart.
- Assert reset during data bit 3 of 0xF0.
  - Required: next cycle serial = 1, ready = 1, busy = 0, and no done pulse.
- Build without UART_TX_PARITY_EN, with STOP_BITS = 2. Send 0xFF with par_en = 1.
  - Required: 11-cycle frame 0, eight 1s, then two stop 1s.
  - Required: no parity bit, and done pulses after the second stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
// Build option UART_TX_PARITY_EN (see uart_tx_serializer) enables the parity bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_PAR_EVEN  = 1'b0;
  localparam logic UART_PAR_ODD   = 1'b1;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for a UART frame: even or odd over all data bits.
// Only instantiated when UART_TX_PARITY_EN is defined.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_type_i,
  output logic                  par_bit_o
);

  assign par_bit_o = (par_type_i == UART_PAR_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer running on the baud clock: start, LSB-first data, optional parity, stop.
// Define UART_TX_PARITY_EN to compile in the parity bit; otherwise the par ports are ignored.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_uart_tx_clk,
  input  logic                  i_uart_tx_rst_n,
  input  logic [DATA_WIDTH-1:0] i_uart_tx_data,
  input  logic                  i_uart_tx_valid,
  input  logic                  i_uart_tx_par_en,
  input  logic                  i_uart_tx_par_type,
  output logic                  o_uart_tx_ready,
  output logic                  o_uart_tx_serial,
  output logic                  o_uart_tx_busy,
  output logic                  o_uart_tx_done
);

  localparam int               CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_e        state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  serial_q, serial_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_type_q, par_type_d;
  logic par_bit;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i    (data_q),
    .par_type_i(par_type_q),
    .par_bit_o (par_bit)
  );
`else
  logic unused_par;
  assign unused_par = i_uart_tx_par_en ^ i_uart_tx_par_type;
`endif

  // ready is registered from the next state, so it equals IDLE || last stop bit.
  assign accept = i_uart_tx_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    serial_d   = serial_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
`endif

    if (accept) begin
      data_d     = i_uart_tx_data;
`ifdef UART_TX_PARITY_EN
      par_en_d   = i_uart_tx_par_en;
      par_type_d = i_uart_tx_par_type;
`endif
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          serial_d = UART_START_LVL;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
        serial_d  = data_q[0];
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          serial_d   = UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d  = PARITY;
            serial_d = par_bit;
          end
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          serial_d  = data_q[bit_cnt_d];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = 1'b0;
        serial_d   = UART_IDLE_LVL;
      end
`endif
      STOP: begin
        if (stop_cnt_q == LAST_STOP) begin
          done_d     = 1'b1;
          stop_cnt_d = 1'b0;
          if (accept) begin
            state_d  = START;
            serial_d = UART_START_LVL;
          end else begin
            state_d  = IDLE;
            serial_d = UART_IDLE_LVL;
          end
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = UART_IDLE_LVL;
      end
    endcase

    ready_d = (state_d == IDLE) || ((state_d == STOP) && (stop_cnt_d == LAST_STOP));
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_uart_tx_clk) begin
    if (!i_uart_tx_rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      serial_q   <= UART_IDLE_LVL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      serial_q   <= serial_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Holding registers only change on accept, so they need no reset.
  always_ff @(posedge i_uart_tx_clk) begin
    data_q <= data_d;
`ifdef UART_TX_PARITY_EN
    par_en_q   <= par_en_d;
    par_type_q <= par_type_d;
`endif
  end

  assign o_uart_tx_ready  = ready_q;
  assign o_uart_tx_serial = serial_q;
  assign o_uart_tx_busy   = busy_q;
  assign o_uart_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer; parity build (UART_TX_PARITY_EN) uses 1 stop bit,
// default build uses 2 stop bits and expects the par ports to be ignored.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int STOP      = 1;
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam int STOP      = 2;
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       par_en;
  logic       par_type;
  logic       ready;
  logic       serial;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_serializer #(
    .DATA_WIDTH(8),
    .STOP_BITS (STOP)
  ) dut (
    .i_uart_tx_clk     (clk),
    .i_uart_tx_rst_n   (rst_n),
    .i_uart_tx_data    (data),
    .i_uart_tx_valid   (valid),
    .i_uart_tx_par_en  (par_en),
    .i_uart_tx_par_type(par_type),
    .o_uart_tx_ready   (ready),
    .o_uart_tx_serial  (serial),
    .o_uart_tx_busy    (busy),
    .o_uart_tx_done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line sequence: start, LSB-first data, parity (if present), stop bits.
  task automatic build_frame(input logic [7:0] d, input logic has_par, input logic exp_par,
                             output logic bits[16], output int n);
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[n++] = d[i];
    if (has_par) bits[n++] = exp_par;
    for (int i = 0; i < STOP; i++) bits[n++] = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; drives one frame and checks every cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic pt, input logic exp_par);
    logic bits[16];
    int   n;
    build_frame(d, PAR_BUILD && pe, exp_par, bits, n);
    check({tag, "_ready_pre"}, ready, 1);
    valid = 1'b1; data = d; par_en = pe; par_type = pt;
    @(negedge clk);
    valid = 1'b0; data = ~d; par_en = ~pe; par_type = ~pt;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), serial, bits[i]);
      check($sformatf("%s_busy%0d", tag, i), busy, 1);
      check($sformatf("%s_rdy%0d", tag, i), ready, (i == n - 1));
      check($sformatf("%s_nodone%0d", tag, i), done, 0);
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_line"}, serial, 1);
    @(negedge clk);
    check({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    logic bits1[16];
    logic bits2[16];
    int   n1;
    int   n2;

    rst_n = 1'b0; valid = 1'b1; data = 8'hA5; par_en = 1'b1; par_type = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_serial", serial, 1);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_serial", serial, 1);
    check("post_rst_busy", busy, 0);

    // 0xA5: 4 ones, even parity bit = 0
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
`ifdef UART_TX_PARITY_EN
    run_frame("01_odd", 8'h01, 1'b1, 1'b1, 1'b0);
    run_frame("03_odd", 8'h03, 1'b1, 1'b1, 1'b1);
    run_frame("c3_nopar", 8'hC3, 1'b0, 1'b0, 1'b0);
`else
    run_frame("ff_ign_par", 8'hFF, 1'b1, 1'b0, 1'b0);
    run_frame("3c_ign_par", 8'h3C, 1'b1, 1'b1, 1'b0);
`endif

    // Back-to-back: 0x55 (4 ones, even parity 0) then 0x0F (4 ones, even parity 0).
    build_frame(8'h55, PAR_BUILD, 1'b0, bits1, n1);
    build_frame(8'h0F, PAR_BUILD, 1'b0, bits2, n2);
    valid = 1'b1; data = 8'h55; par_en = 1'b1; par_type = 1'b0;
    @(negedge clk);
    data = 8'h0F;
    for (int i = 0; i < n1 + n2 + 1; i++) begin
      if (i == n1) valid = 1'b0;
      if (i < n1) check($sformatf("b2b_f1_bit%0d", i), serial, bits1[i]);
      else if (i < n1 + n2) check($sformatf("b2b_f2_bit%0d", i - n1), serial, bits2[i - n1]);
      else check("b2b_idle_line", serial, 1);
      check($sformatf("b2b_done%0d", i), done, (i == n1) || (i == n1 + n2));
      check($sformatf("b2b_busy%0d", i), busy, (i < n1 + n2));
      @(negedge clk);
    end
    check("b2b_after_done", done, 0);

    // Abort 0xF0 while data bit 3 is on the line.
    valid = 1'b1; data = 8'hF0; par_en = 1'b0; par_type = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_bit%0d", i), serial, (i == 0) ? 1'b0 : 1'b0);
      @(negedge clk);
    end
    check("abort_bit3_shown", serial, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_serial", serial, 1);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_done%0d", i), done, 0);
      check($sformatf("abort_quiet_line%0d", i), serial, 1);
    end

    // Normal operation resumes after the abort.
    run_frame("after_abort_81", 8'h81, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
